maxpool_stream: RTL

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the rectifier layer in the CNN datapath. It consumes one multi-channel pixel per beat in raster order, keeps half a row of partial maxima, and emits one pooled multi-channel pixel per 2×2 window. Valid/ready handshakes are used on both sides.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/maxpool_cmp.sv | 24 ++
 rtl/maxpool_stream.sv | 91 +++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel types and channel max helper for the CNN datapath layers.
// Macro MAXPOOL_SIGNED_EN selects two's-complement comparison in px_max (default unsigned).
package cnn_pkg;
    localparam int PX_SIZE        = 8;
    localparam int INPUT_CHANNELS = 3;
    typedef logic [PX_SIZE-1:0] px_t;
    typedef px_t [INPUT_CHANNELS-1:0] chan_vec_t;
    function automatic px_t px_max(input px_t a, input px_t b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) >= $signed(b)) ? a : b;
`else
        return (a >= b) ? a : b;
`endif
    endfunction
endpackage

// File: rtl/maxpool_cmp.sv
// maxpool_cmp: combinational channel-wise max of two channel vectors.
// Ports: a, b -- CH channels of PX_SIZE bits each; y -- per-channel max(a, b).
// Macro MAXPOOL_SIGNED_EN selects signed comparison (default unsigned).
module maxpool_cmp #(
    parameter int CH      = 3,
    parameter int PX_SIZE = cnn_pkg::PX_SIZE
) (
    input  logic [CH-1:0][PX_SIZE-1:0] a,
    input  logic [CH-1:0][PX_SIZE-1:0] b,
    output logic [CH-1:0][PX_SIZE-1:0] y
);
    for (genvar c = 0; c < CH; c++) begin : g_ch
        // The shared helper is fixed to the package width; other widths compare inline.
        if (PX_SIZE == cnn_pkg::PX_SIZE) begin : g_pkg
            assign y[c] = cnn_pkg::px_max(a[c], b[c]);
        end else begin : g_gen
`ifdef MAXPOOL_SIGNED_EN
            assign y[c] = ($signed(a[c]) >= $signed(b[c])) ? a[c] : b[c];
`else
            assign y[c] = (a[c] >= b[c]) ? a[c] : b[c];
`endif
        end
    end
endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 stride-2 max-pooling over a raster-order pixel stream.
// Ports: clk, rst_n (async active-low); in_px/in_valid/in_ready input stream;
//        out_px/out_valid/out_ready/out_last pooled output stream (out_last on the final window).
// Macro MAXPOOL_SIGNED_EN selects signed channel comparison (default unsigned).
module maxpool_stream #(
    parameter int INPUT_SIZE     = 4,
    parameter int INPUT_CHANNELS = 3,
    parameter int PX_SIZE        = cnn_pkg::PX_SIZE
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] in_px,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] out_px,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last
);
    localparam int CW   = $clog2(INPUT_SIZE);
    localparam int HALF = INPUT_SIZE / 2;
    localparam int LW   = (CW > 1) ? CW - 1 : 1;
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

    if (INPUT_SIZE < 2 || INPUT_SIZE % 2 != 0) begin : g_bad_size
        $error("maxpool_stream: INPUT_SIZE must be even and at least 2");
    end

    typedef logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] vec_t;

    logic [CW-1:0] col_q, col_d, row_q, row_d;
    vec_t          h_hold_q, h_hold_d;
    vec_t          lbuf_q [HALF];
    vec_t          lbuf_d [HALF];
    vec_t          out_px_q, out_px_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    vec_t          pair, win;
    logic [LW-1:0] idx;
    logic          acc, load;

    assign idx = LW'(col_q >> 1);

    maxpool_cmp #(.CH(INPUT_CHANNELS), .PX_SIZE(PX_SIZE)) u_hcmp (
        .a(h_hold_q), .b(in_px), .y(pair)
    );
    maxpool_cmp #(.CH(INPUT_CHANNELS), .PX_SIZE(PX_SIZE)) u_vcmp (
        .a(lbuf_q[idx]), .b(pair), .y(win)
    );

    // Single-entry output register: accept only when the slot is free or draining.
    assign in_ready  = !out_valid_q || out_ready;
    assign out_px    = out_px_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    always_comb begin
        acc         = in_valid && in_ready;
        load        = acc && col_q[0] && row_q[0];
        col_d       = acc ? ((col_q == LAST) ? '0 : col_q + 1'b1) : col_q;
        row_d       = (acc && col_q == LAST) ? ((row_q == LAST) ? '0 : row_q + 1'b1) : row_q;
        h_hold_d    = (acc && !col_q[0]) ? in_px : h_hold_q;
        lbuf_d      = lbuf_q;
        if (acc && col_q[0] && !row_q[0]) lbuf_d[idx] = pair;
        out_px_d    = load ? win : out_px_q;
        out_last_d  = load ? (col_q == LAST && row_q == LAST) : out_last_q;
        out_valid_d = load || (out_valid_q && !out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_px_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_px_q    <= out_px_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Partial maxima are always written before being read within a frame, so no reset.
    always_ff @(posedge clk) begin
        h_hold_q <= h_hold_d;
        lbuf_q   <= lbuf_d;
    end
endmodule
